// File: rtl/flash_wip_poll.sv
// rtl/flash_wip_poll.sv - Repeats SPI Read Status Register (0x05) until WIP clears or a timeout expires
module flash_wip_poll #(
    parameter int          CLK_DIV     = 4,
    parameter int          POLL_GAP    = 5,
    parameter logic [27:0] TIMEOUT_CYC = 28'd150_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       miso,
    output logic       cs_n,
    output logic       sck,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] status
);
    localparam int               CNT_W    = 16;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_q;
    logic [15:0]      tx_q;
    logic [7:0]       rx_q;
    logic [27:0]      tmo_q;
    logic             cs_n_q;
    logic             sck_q;
    logic             mosi_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic [7:0]       status_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            tmo_q     <= '0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            status_q  <= 8'h00;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (busy_q && (tmo_q != '1)) begin
                tmo_q <= tmo_q + 28'd1;
            end

            case (state_q)
                IDLE: begin
                    cs_n_q <= 1'b1;
                    sck_q  <= 1'b0;
                    mosi_q <= 1'b0;
                    if (start) begin
                        state_q <= CS_SETUP;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                        cnt_q   <= '0;
                    end
                end

                CS_SETUP: begin
                    if (cnt_q == DIV_LAST) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        // First frame bit goes out now; tx_q holds the bits still to send.
                        mosi_q  <= 1'b0;
                        tx_q    <= 16'h0A00;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                SHIFT: begin
                    if (cnt_q == DIV_HALF) begin
                        sck_q <= 1'b1;
                        if (bit_q[3]) begin
                            rx_q <= {rx_q[6:0], miso};
                        end
                        cnt_q <= cnt_q + 1'b1;
                    end else if (cnt_q == DIV_LAST) begin
                        sck_q <= 1'b0;
                        cnt_q <= '0;
                        if (bit_q == 4'd15) begin
                            state_q  <= CS_HOLD;
                            mosi_q   <= 1'b0;
                            status_q <= rx_q;
                        end else begin
                            bit_q  <= bit_q + 4'd1;
                            mosi_q <= tx_q[15];
                            tx_q   <= {tx_q[14:0], 1'b0};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                CS_HOLD: begin
                    if (cnt_q == DIV_LAST) begin
                        state_q <= GAP;
                        cs_n_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        // Only WIP decides; the timeout is checked between polls, never mid-frame.
                        if (!status_q[0]) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else if (tmo_q >= TIMEOUT_CYC) begin
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= CS_SETUP;
                            cs_n_q  <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign cs_n    = cs_n_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign status  = status_q;
endmodule

// File: tb/tb_flash_wip_poll.sv
// tb/tb_flash_wip_poll.sv - Randomized self-checking bench for flash_wip_poll against a poll-level model
module tb_flash_wip_poll;
    localparam int     CLK_DIV  = 4;
    localparam int     POLL_GAP = 5;
    localparam int     POLL_LEN = CLK_DIV + 16 * CLK_DIV + CLK_DIV + POLL_GAP;
    localparam int     CS_LOW   = POLL_LEN - POLL_GAP;
    localparam longint TMO_DEF  = 150_000_000;
    localparam longint TMO_T    = 200;

    logic sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    logic       sys_rst = 1'b1;
    logic       start   = 1'b0;
    logic       start_t = 1'b0;
    logic       miso    = 1'b0;
    logic       miso_t  = 1'b1;
    logic       cs_n, sck, mosi, busy, done, timeout;
    logic [7:0] status;
    logic       cs_n_t, sck_t, mosi_t, busy_t, done_t, timeout_t;
    logic [7:0] status_t;

    flash_wip_poll #(.CLK_DIV(CLK_DIV), .POLL_GAP(POLL_GAP)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .miso(miso),
        .cs_n(cs_n), .sck(sck), .mosi(mosi), .busy(busy), .done(done),
        .timeout(timeout), .status(status)
    );

    flash_wip_poll #(.CLK_DIV(CLK_DIV), .POLL_GAP(POLL_GAP), .TIMEOUT_CYC(28'd200)) dut_t (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_t), .miso(miso_t),
        .cs_n(cs_n_t), .sck(sck_t), .mosi(mosi_t), .busy(busy_t), .done(done_t),
        .timeout(timeout_t), .status(status_t)
    );

    logic       sel_t = 1'b0;
    logic       o_cs, o_sck, o_mosi, o_busy, o_done, o_to;
    logic [7:0] o_stat;
    assign o_cs   = sel_t ? cs_n_t    : cs_n;
    assign o_sck  = sel_t ? sck_t     : sck;
    assign o_mosi = sel_t ? mosi_t    : mosi;
    assign o_busy = sel_t ? busy_t    : busy;
    assign o_done = sel_t ? done_t    : done;
    assign o_to   = sel_t ? timeout_t : timeout;
    assign o_stat = sel_t ? status_t  : status;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Flash model: answers each cs_n-low frame with the next byte of resp_q
    logic [7:0]  resp_q[$];
    int          poll_idx = 0;
    int          rise_cnt = 0;
    logic [15:0] mosi_sh  = '0;
    logic [7:0]  cur_byte = '0;

    always @(negedge cs_n) begin
        rise_cnt = 0;
        mosi_sh  = '0;
        miso     = 1'b0;
        if (resp_q.size() == 0) cur_byte = 8'h00;
        else if (poll_idx < resp_q.size()) cur_byte = resp_q[poll_idx];
        else cur_byte = resp_q[resp_q.size() - 1];
        poll_idx++;
    end

    always @(posedge sck) begin
        if (!cs_n) begin
            mosi_sh = {mosi_sh[14:0], mosi};
            rise_cnt++;
        end
    end

    always @(negedge sck) begin
        if (!cs_n && rise_cnt >= 8 && rise_cnt < 16) miso = cur_byte[15 - rise_cnt];
    end

    always @(posedge cs_n) begin
        if (rise_cnt == 16) check("mosi_frame", 32'(mosi_sh), 32'h0000_0500);
    end

    // Poll-level reference: walk the status bytes poll by poll
    function automatic void predict(input logic [7:0] seq[$], input longint tmo,
                                    output int polls, output bit is_done, output logic [7:0] last);
        polls   = 0;
        is_done = 1'b0;
        last    = 8'h00;
        for (int n = 1; n <= 64; n++) begin
            last  = (n <= seq.size()) ? seq[n - 1] : seq[seq.size() - 1];
            polls = n;
            if (!last[0]) begin
                is_done = 1'b1;
                return;
            end
            if (longint'(n * POLL_LEN - 1) >= tmo) return;
        end
    endfunction

    task automatic run_op(input string tag, input bit use_t, input logic [7:0] seq[$],
                          input longint tmo, input int ign_a, input int ign_b, input int rst_at);
        int         polls, exp_end, limit;
        bit         exp_done;
        logic [7:0] exp_stat;
        int         done_cnt, to_cnt, end_k, windows, win_len;
        bit         prev_cs, win_open, busy_prev;
        predict(seq, tmo, polls, exp_done, exp_stat);
        exp_end  = polls * POLL_LEN;
        resp_q   = seq;
        poll_idx = 0;
        sel_t    = use_t;
        sys_rst  = 1'b0;
        if (use_t) start_t = 1'b1;
        else start = 1'b1;
        @(posedge sys_clk);
        #1;
        start   = 1'b0;
        start_t = 1'b0;
        check({tag, ".cs_low_edge0"}, 32'(o_cs), 32'd0);
        check({tag, ".busy_edge0"}, 32'(o_busy), 32'd1);
        done_cnt  = 0;
        to_cnt    = 0;
        end_k     = -1;
        windows   = 1;
        win_len   = 1;
        win_open  = 1'b1;
        prev_cs   = o_cs;
        busy_prev = o_busy;
        limit     = (rst_at > 0) ? rst_at : exp_end + 8;
        for (int k = 1; k <= limit; k++) begin
            if (use_t) start_t = (k == ign_a || k == ign_b);
            else start = (k == ign_a || k == ign_b);
            sys_rst = (k == rst_at);
            if (k == end_k + 1 && end_k >= 0) break;
            @(posedge sys_clk);
            #1;
            start   = 1'b0;
            start_t = 1'b0;
            sys_rst = 1'b0;
            if (k == rst_at) begin
                check({tag, ".rst_cs_n"}, 32'(o_cs), 32'd1);
                check({tag, ".rst_sck"}, 32'(o_sck), 32'd0);
                check({tag, ".rst_mosi"}, 32'(o_mosi), 32'd0);
                check({tag, ".rst_busy"}, 32'(o_busy), 32'd0);
                check({tag, ".rst_status"}, 32'(o_stat), 32'h00);
                check({tag, ".rst_pulses"}, 32'(done_cnt + to_cnt + int'(o_done) + int'(o_to)), 32'd0);
                break;
            end
            if (o_done) begin
                done_cnt++;
                if (end_k < 0) end_k = k;
            end
            if (o_to) begin
                to_cnt++;
                if (end_k < 0) end_k = k;
            end
            if (win_open) begin
                if (o_cs) win_open = 1'b0;
                else win_len++;
            end
            if (!o_cs && prev_cs) windows++;
            prev_cs = o_cs;
            if (end_k >= 0) break;
            busy_prev = o_busy;
        end
        if (rst_at <= 0) begin
            check({tag, ".end_cycle"}, 32'(end_k), 32'(exp_end));
            check({tag, ".done_cnt"}, 32'(done_cnt), exp_done ? 32'd1 : 32'd0);
            check({tag, ".timeout_cnt"}, 32'(to_cnt), exp_done ? 32'd0 : 32'd1);
            check({tag, ".windows"}, 32'(windows), 32'(polls));
            check({tag, ".cs_low_len"}, 32'(win_len), 32'(CS_LOW));
            check({tag, ".status"}, 32'(o_stat), 32'(exp_stat));
            check({tag, ".busy_before_end"}, 32'(busy_prev), 32'd1);
            check({tag, ".busy_at_end"}, 32'(o_busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset.cs_n", 32'(cs_n), 32'd1);
        check("reset.sck", 32'(sck), 32'd0);
        check("reset.mosi", 32'(mosi), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.pulses", 32'({done, timeout}), 32'd0);
        check("reset.status", 32'(status), 32'h00);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        q = '{8'h00};
        run_op("single", 1'b0, q, TMO_DEF, -1, -1, -1);
        repeat (2) @(posedge sys_clk);
        #1;
        q = '{8'h03, 8'h03, 8'h03, 8'h00};
        run_op("four_polls", 1'b0, q, TMO_DEF, -1, -1, -1);
        q = '{8'hFF};
        run_op("timeout", 1'b1, q, TMO_T, -1, -1, -1);
        q = '{8'h02};
        run_op("wel_only", 1'b0, q, TMO_DEF, -1, -1, -1);
        q = '{8'h03, 8'h00};
        run_op("ignore_start", 1'b0, q, TMO_DEF, 10, 76, -1);
        q = '{8'h00};
        run_op("back_to_back", 1'b0, q, TMO_DEF, -1, -1, -1);
        q = '{8'h03, 8'h00};
        run_op("mid_reset", 1'b0, q, TMO_DEF, -1, -1, 30);
        q = '{8'h01, 8'h00};
        run_op("after_reset", 1'b0, q, TMO_DEF, -1, -1, -1);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, 4));
            q = {};
            for (int i = 0; i < n - 1; i++) q.push_back(8'($urandom()) | 8'h01);
            q.push_back(8'($urandom()) & 8'hFE);
            run_op($sformatf("rand%0d", t), 1'b0, q, TMO_DEF, -1, -1, -1);
            repeat (int'($urandom_range(0, 3))) @(posedge sys_clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
